// File: rtl/data_check_pkg.sv
// Shared types and helpers for the data_check stream sink.
// The optional throttle (macro DATA_CHECK_THROTTLE_EN) uses the LFSR constants here.
package data_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   // 16-bit Galois LFSR, taps 16,14,13,11 (right-shift form)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

   // Whole beats in a burst of 'size' bytes; residual bytes are dropped.
   function automatic logic [31:0] beats_from_size(input logic [31:0] size,
                                                    input int unsigned width);
      logic [31:0] beats;
      beats = size;
      for (int i = 0; i < 7; i++) begin
         if ((32'd8 << i) == width) beats = size >> i;
      end
      return beats;
   endfunction

endpackage

// File: rtl/data_check_cmp.sv
// Per-beat comparator with saturating error counter and first-error capture.
// Kept separate so other stream sinks can reuse it.
module data_check_cmp
   import data_check_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic [WIDTH-1:0] tdata,
   input  logic             tlast,
   input  logic [WIDTH-1:0] exp_data,
   input  logic             exp_last,
   input  logic [31:0]      beat_idx,
   output logic             beat_err,
   output logic [31:0]      err_count,
   output logic [31:0]      err_first_idx,
   output logic [WIDTH-1:0] err_first_data
);

   // One error per beat, however many fields are wrong
   assign beat_err = accept && ((tdata != exp_data) || (tlast != exp_last));

   // Error counter saturates; first-error fields latch only while the count is zero
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         err_count      <= '0;
         err_first_idx  <= '0;
         err_first_data <= '0;
      end else if (clear) begin
         err_count      <= '0;
         err_first_idx  <= '0;
         err_first_data <= '0;
      end else if (beat_err) begin
         if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
         if (err_count == 32'd0) begin
            err_first_idx  <= beat_idx;
            err_first_data <= tdata;
         end
      end
   end

endmodule

// File: rtl/data_check.sv
// AXI-Stream sink and pattern checker: expects 'times' bursts of incrementing
// data starting at 0, tlast on the final beat of each burst.
// Optional macro DATA_CHECK_THROTTLE_EN: LFSR-driven tready backpressure in RUN.
//
// state | meaning
// IDLE  | waiting for ap_start, ap_idle high
// RUN   | accepting and checking beats of the current burst
// GAP   | one cycle between bursts, tready low, counters rewound
// DONE  | ap_done pulse, results valid
module data_check
   import data_check_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [31:0]      size,
   input  logic [31:0]      times,
   input  logic             ap_start,
   output logic             ap_idle,
   output logic             ap_ready,
   output logic             ap_done,
   input  logic [WIDTH-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   output logic             pass,
   output logic [31:0]      err_count,
   output logic [31:0]      err_first_idx,
   output logic [WIDTH-1:0] err_first_data
);

   state_t           state_q, state_d;
   logic [31:0]      beats_q;
   logic [31:0]      beats_left_q;
   logic [31:0]      bursts_left_q;
   logic [31:0]      beat_idx_q;
   logic [WIDTH-1:0] expected_q;
   logic [31:0]      beats_in;
   logic             zero_run;
   logic             start_ok;
   logic             accept;
   logic             burst_last;
   logic             beat_err;
   logic             tready_q;
   logic             pass_q;
   logic             throttle_ok;

   assign beats_in   = beats_from_size(size, WIDTH);
   assign zero_run   = (beats_in == 32'd0) || (times == 32'd0);
   assign start_ok   = ap_rst_n && (state_q == IDLE) && ap_start;
   assign accept     = s_axis_tvalid && tready_q;
   assign burst_last = accept && (beats_left_q == 32'd1);

   assign ap_ready      = start_ok;
   assign s_axis_tready = tready_q;
   assign pass          = pass_q;

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state decode and control outputs
   always_comb begin
      state_d = state_q;
      ap_idle = 1'b0;
      ap_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            ap_idle = 1'b1;
            if (start_ok) state_d = zero_run ? DONE : RUN;
         end
         RUN: begin
            if (burst_last) state_d = (bursts_left_q == 32'd1) ? DONE : GAP;
         end
         GAP: begin
            state_d = RUN;
         end
         DONE: begin
            ap_done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DATA_CHECK_THROTTLE_EN
   logic [15:0] lfsr_q, lfsr_d;

   // LFSR reseeds at start and steps every RUN cycle
   always_comb begin
      lfsr_d = lfsr_q;
      if (start_ok)             lfsr_d = LFSR_SEED;
      else if (state_q == RUN)  lfsr_d = lfsr_step(lfsr_q);
   end

   // LFSR register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) lfsr_q <= LFSR_SEED;
      else           lfsr_q <= lfsr_d;
   end

   // tready is registered, so judge the LFSR value it will coincide with
   assign throttle_ok = (lfsr_d[1:0] != 2'b00);
`else
   assign throttle_ok = 1'b1;
`endif

   // Registered tready follows the next-state decision so no extra beat slips in
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) tready_q <= 1'b0;
      else           tready_q <= (state_d == RUN) && throttle_ok;
   end

   // Burst/beat down-counters, global beat index and expected data
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         beats_q       <= '0;
         beats_left_q  <= '0;
         bursts_left_q <= '0;
         beat_idx_q    <= '0;
         expected_q    <= '0;
      end else if (start_ok) begin
         beats_q       <= beats_in;
         beats_left_q  <= beats_in;
         bursts_left_q <= times;
         beat_idx_q    <= '0;
         expected_q    <= '0;
      end else if ((state_q == RUN) && accept) begin
         beats_left_q  <= beats_left_q - 32'd1;
         beat_idx_q    <= beat_idx_q + 32'd1;
         expected_q    <= expected_q + 1'b1;
      end else if (state_q == GAP) begin
         beats_left_q  <= beats_q;
         bursts_left_q <= bursts_left_q - 32'd1;
         expected_q    <= '0;
      end
   end

   // pass clears at start; set on entry to DONE, counting the final beat too
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
         pass_q <= 1'b0;
      else if (start_ok)
         pass_q <= zero_run;
      else if ((state_q == RUN) && (state_d == DONE))
         pass_q <= (err_count == 32'd0) && !beat_err;
   end

   data_check_cmp #(.WIDTH(WIDTH)) u_cmp (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .clear          (start_ok),
      .accept         (accept),
      .tdata          (s_axis_tdata),
      .tlast          (s_axis_tlast),
      .exp_data       (expected_q),
      .exp_last       (beats_left_q == 32'd1),
      .beat_idx       (beat_idx_q),
      .beat_err       (beat_err),
      .err_count      (err_count),
      .err_first_idx  (err_first_idx),
      .err_first_data (err_first_data)
   );

endmodule

// File: tb/tb_data_check.sv
// Scoreboard bench for data_check: one WIDTH=8 and one WIDTH=32 instance,
// selected by 'sel'; a monitor checks results at every ap_done.
module tb_data_check;

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic [31:0] size   = '0;
   logic [31:0] times  = '0;
   logic [31:0] tdata  = '0;
   logic        start  = 1'b0;
   logic        tvalid = 1'b0;
   logic        tlast  = 1'b0;
   logic        sel    = 1'b0;

   logic        idle8, ready8, done8, tready8, pass8;
   logic [31:0] cnt8, idx8;
   logic [7:0]  fdat8;
   logic        idle32, ready32, done32, tready32, pass32;
   logic [31:0] cnt32, idx32, fdat32;

   data_check #(.WIDTH(8)) dut8 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .size(size), .times(times),
      .ap_start(start & ~sel), .ap_idle(idle8), .ap_ready(ready8), .ap_done(done8),
      .s_axis_tdata(tdata[7:0]), .s_axis_tvalid(tvalid & ~sel), .s_axis_tlast(tlast),
      .s_axis_tready(tready8), .pass(pass8), .err_count(cnt8),
      .err_first_idx(idx8), .err_first_data(fdat8));

   data_check #(.WIDTH(32)) dut32 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .size(size), .times(times),
      .ap_start(start & sel), .ap_idle(idle32), .ap_ready(ready32), .ap_done(done32),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & sel), .s_axis_tlast(tlast),
      .s_axis_tready(tready32), .pass(pass32), .err_count(cnt32),
      .err_first_idx(idx32), .err_first_data(fdat32));

   logic        m_idle, m_ready, m_done, m_tready, m_pass;
   logic [31:0] m_cnt, m_idx, m_fdat;

   always_comb begin
      if (sel) begin
         m_idle = idle32; m_ready = ready32; m_done = done32; m_tready = tready32;
         m_pass = pass32; m_cnt = cnt32; m_idx = idx32; m_fdat = fdat32;
      end else begin
         m_idle = idle8; m_ready = ready8; m_done = done8; m_tready = tready8;
         m_pass = pass8; m_cnt = cnt8; m_idx = idx8; m_fdat = {24'h0, fdat8};
      end
   end

   typedef struct {
      logic [31:0] pass;
      logic [31:0] cnt;
      logic [31:0] idx;
      logic [31:0] data;
      int          total;
      int          bpb;
      bit          zero;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #2;
   endtask

   // Monitor: handshake bookkeeping and result checks at each ap_done
   int acc_cnt = 0, last_acc_cyc = 0, ready_cyc = 0, tr_cnt = 0, cur_bpb = 0;
   bit gap_chk = 0;
   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst_n) begin
         gap_chk = 0;
      end else begin
         if (gap_chk) begin
            chk("tready_low_after_burst", 32'(m_tready), 32'd0);
            gap_chk = 0;
         end
         if (m_ready) begin
            ready_cyc = cyc;
            acc_cnt   = 0;
            tr_cnt    = 0;
            cur_bpb   = (sb.size() > 0) ? sb[0].bpb : 0;
         end
         if (m_tready) tr_cnt++;
         if (tvalid && m_tready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            if (cur_bpb > 0 && (acc_cnt % cur_bpb) == 0) gap_chk = 1;
         end
         if (m_done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done got=1 exp=0 t=%0t", $time);
            end else begin
               e = sb.pop_front();
               chk("pass", 32'(m_pass), e.pass);
               chk("err_count", m_cnt, e.cnt);
               chk("err_first_idx", m_idx, e.idx);
               chk("err_first_data", m_fdat, e.data);
               chk("beats_accepted", acc_cnt, e.total);
               if (e.zero) begin
                  chk("done_after_ready", cyc, ready_cyc + 1);
                  chk("tready_never_high", tr_cnt, 32'd0);
               end else begin
                  chk("done_latency", cyc, last_acc_cyc + 1);
               end
            end
         end
      end
   end

   // One run: build beats with optional faults, model the result, drive it
   task automatic run_test(input bit s, input int sz, input int tm, input int gap,
                           input int err_pct, input int fd_idx, input logic [31:0] fd_val,
                           input int fl_idx, input int abort_idx);
      int          w, bpb, nbeats, to;
      logic [31:0] mask, d;
      bit          l;
      logic [31:0] bd[$];
      bit          bl[$];
      exp_t        e;
      w      = s ? 32 : 8;
      mask   = s ? 32'hFFFF_FFFF : 32'h0000_00FF;
      bpb    = sz / (w / 8);
      nbeats = (tm == 0) ? 0 : bpb * tm;
      e.pass = 32'd1; e.cnt = 0; e.idx = 0; e.data = 0;
      e.total = nbeats; e.bpb = bpb; e.zero = (nbeats == 0);
      for (int g = 0; g < nbeats; g++) begin
         int i;
         i = g % bpb;
         d = 32'(i) & mask;
         l = (i == bpb - 1);
         if (g == fd_idx) d = fd_val & mask;
         if (g == fl_idx) l = !l;
         if (err_pct > 0 && $urandom_range(99, 0) < err_pct) begin
            if ($urandom_range(1, 0) == 1) d = d ^ (($urandom & mask) | 32'd1);
            else                           l = !l;
         end
         if (d != (32'(i) & mask) || l != (i == bpb - 1)) begin
            if (e.cnt == 0) begin
               e.idx  = 32'(g);
               e.data = d;
            end
            e.cnt  = e.cnt + 1;
            e.pass = 32'd0;
         end
         bd.push_back(d);
         bl.push_back(l);
      end
      sb.push_back(e);
      sel   = s;
      size  = 32'(sz);
      times = 32'(tm);
      start = 1'b1;
      #1;
      chk("ap_ready", 32'(m_ready), 32'd1);
      tick();
      start = 1'b0;
      chk("ap_idle_in_run", 32'(m_idle), 32'd0);
      for (int g = 0; g < nbeats; g++) begin
         if (g == abort_idx) begin
            ap_rst_n = 1'b0;
            tvalid   = 1'b0;
            #1;
            chk("rst_tready", 32'(m_tready), 32'd0);
            chk("rst_idle", 32'(m_idle), 32'd1);
            chk("rst_done", 32'(m_done), 32'd0);
            chk("rst_err_count", m_cnt, 32'd0);
            e = sb.pop_back();
            repeat (3) tick();
            ap_rst_n = 1'b1;
            repeat (3) tick();
            chk("idle_after_abort", 32'(m_idle), 32'd1);
            return;
         end
         if (gap > 0)      repeat (gap) tick();
         else if (gap < 0) repeat ($urandom_range(2, 0)) tick();
         tvalid = 1'b1;
         tdata  = bd[g];
         tlast  = bl[g];
         to = 0;
         while (!m_tready && to < 100) begin
            tick();
            to++;
         end
         if (!m_tready) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout beat=%0d got=0 exp=1", g);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "handshake timeout");
         end
         tick();
         tvalid = 1'b0;
         tlast  = 1'b0;
      end
      to = 0;
      while (!m_idle && to < 20) begin
         tick();
         to++;
      end
      chk("idle_after_run", 32'(m_idle), 32'd1);
      tick();
   endtask

   initial begin
      #1;
      chk("rst8_idle", 32'(idle8), 32'd1);
      chk("rst8_ready", 32'(ready8), 32'd0);
      chk("rst8_done", 32'(done8), 32'd0);
      chk("rst8_tready", 32'(tready8), 32'd0);
      chk("rst8_pass", 32'(pass8), 32'd0);
      chk("rst8_cnt", cnt8, 32'd0);
      chk("rst8_idx", idx8, 32'd0);
      chk("rst8_data", 32'(fdat8), 32'd0);
      chk("rst32_idle", 32'(idle32), 32'd1);
      chk("rst32_tready", 32'(tready32), 32'd0);
      chk("rst32_data", fdat32, 32'd0);
      tick();
      tick();
      ap_rst_n = 1'b1;
      tick();
      // sel, size, times, gap, err%, data-fault idx/val, tlast-fault idx, abort idx
      run_test(1'b0, 16, 1, 0, 0, -1, 32'h0, -1, -1);
      run_test(1'b1, 64, 3, 2, 0, -1, 32'h0, -1, -1);
      run_test(1'b0, 8, 1, 0, 0, 5, 32'hFF, -1, -1);
      run_test(1'b0, 8, 1, 0, 0, 6, 32'h77, 3, -1);
      run_test(1'b1, 3, 1, 0, 0, -1, 32'h0, -1, -1);
      run_test(1'b0, 5, 0, 0, 0, -1, 32'h0, -1, -1);
      run_test(1'b1, 16, 3, 0, 0, -1, 32'h0, -1, 6);
      run_test(1'b1, 16, 3, -1, 0, -1, 32'h0, -1, -1);
      for (int r = 0; r < 24; r++) begin
         run_test(1'($urandom_range(1, 0)), int'($urandom_range(40, 0)),
                  int'($urandom_range(3, 0)), -1,
                  ($urandom_range(1, 0) == 1) ? 20 : 0, -1, 32'h0, -1, -1);
      end
      tick();
      tick();
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
